icache_ctrl: RTL

- Direct-mapped, one-word-per-line instruction cache controller between the IF stage and the memory allocator's IF port.
- Serves hits from local arrays. On a miss it sequences a 4-byte refill through the allocator handshake, then fills the line and returns the instruction.
- Aborts cleanly on branch clear.
- Keeps hit/miss performance counters.

---
 rtl/icache_ctrl_pkg.sv | 21 ++
 rtl/icache_ctrl_if.sv | 26 ++
 rtl/icache_ctrl_array.sv | 46 ++++
 rtl/icache_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared widths, FSM encodings and helpers for the instruction cache controller.
package icache_ctrl_pkg;

    localparam int AddrWidth        = 32;
    localparam int InstrWidth       = 32;
    localparam int ICacheIndexWidth = 6;
    localparam int ICacheTagWidth   = AddrWidth - ICacheIndexWidth - 2;

    localparam logic [1:0] ICIdle = 2'd0;
    localparam logic [1:0] ICMiss = 2'd1;
    localparam logic [1:0] ICResp = 2'd2;

    // Every refill is one full 4-byte word, so the last byte offset never changes.
    localparam logic [1:0]  ICOffset = 2'b11;
    localparam logic [31:0] CntMax   = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CntMax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and allocator-side handshake bundle of the instruction cache.
interface icache_ctrl_if;
    import icache_ctrl_pkg::*;

    logic                  if_req_in;
    logic [AddrWidth-1:0]  if_addr_in;
    logic                  ic_valid_out;
    logic [InstrWidth-1:0] ic_instr_out;
    logic                  ic_to_alloc_en_out;
    logic [AddrWidth-1:0]  ic_a_out;
    logic [1:0]            ic_offset_out;
    logic                  alloc_to_ic_gr_in;
    logic                  alloc_to_ic_en_in;
    logic [InstrWidth-1:0] alloc_d_in;

    modport slave (
        input  if_req_in, if_addr_in, alloc_to_ic_gr_in, alloc_to_ic_en_in, alloc_d_in,
        output ic_valid_out, ic_instr_out, ic_to_alloc_en_out, ic_a_out, ic_offset_out
    );

    modport master (
        output if_req_in, if_addr_in, alloc_to_ic_gr_in, alloc_to_ic_en_in, alloc_d_in,
        input  ic_valid_out, ic_instr_out, ic_to_alloc_en_out, ic_a_out, ic_offset_out
    );

endinterface

// File: rtl/icache_ctrl_array.sv
// Direct-mapped valid/tag/data storage: combinational read, synchronous single write.
module icache_ctrl_array
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_W = ICacheIndexWidth,
    parameter int TAG_W   = ICacheTagWidth
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [INDEX_W-1:0]    rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [InstrWidth-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [InstrWidth-1:0] wr_data
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [InstrWidth-1:0] data_mem [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction cache controller: lookup FSM, allocator refill handshake, hit/miss counters.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_W = ICacheIndexWidth,
    parameter int TAG_W   = AddrWidth - INDEX_W - 2
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          clear_branch_in,
    icache_ctrl_if.slave  bus,
    output logic [31:0]   hit_cnt_out,
    output logic [31:0]   miss_cnt_out
);

    logic [1:0]            state;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [InstrWidth-1:0] rd_data;
    logic                  lookup_hit;
    logic                  fill;
    logic                  unused_bits;

    assign lookup_hit = rd_valid && (rd_tag == bus.if_addr_in[AddrWidth-1:INDEX_W+2]);

    // The latched miss address in ic_a_out doubles as the fill index/tag.
    assign fill = rst_n_in && rdy_in && !clear_branch_in &&
                  (state == ICMiss) && bus.alloc_to_ic_en_in;

    assign bus.ic_offset_out = ICOffset;
    assign unused_bits       = ^{bus.alloc_to_ic_gr_in, bus.if_addr_in[1:0]};

    icache_ctrl_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rd_idx   (bus.if_addr_in[INDEX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill),
        .wr_idx   (bus.ic_a_out[INDEX_W+1:2]),
        .wr_tag   (bus.ic_a_out[AddrWidth-1:INDEX_W+2]),
        .wr_data  (bus.alloc_d_in)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state                  <= ICIdle;
            bus.ic_valid_out       <= 1'b0;
            bus.ic_instr_out       <= '0;
            bus.ic_to_alloc_en_out <= 1'b0;
            bus.ic_a_out           <= '0;
            hit_cnt_out            <= '0;
            miss_cnt_out           <= '0;
        end else if (rdy_in) begin
            bus.ic_valid_out <= 1'b0;
            if (clear_branch_in) begin
                bus.ic_to_alloc_en_out <= 1'b0;
                state                  <= ICIdle;
            end else begin
                case (state)
                    ICIdle: begin
                        if (bus.if_req_in) begin
                            if (lookup_hit) begin
                                bus.ic_instr_out <= rd_data;
                                bus.ic_valid_out <= 1'b1;
                                hit_cnt_out      <= sat_inc(hit_cnt_out);
                                state            <= ICResp;
                            end else begin
                                bus.ic_a_out           <= bus.if_addr_in;
                                bus.ic_to_alloc_en_out <= 1'b1;
                                miss_cnt_out           <= sat_inc(miss_cnt_out);
                                state                  <= ICMiss;
                            end
                        end
                    end
                    ICMiss: begin
                        if (bus.alloc_to_ic_en_in) begin
                            bus.ic_instr_out       <= bus.alloc_d_in;
                            bus.ic_valid_out       <= 1'b1;
                            bus.ic_to_alloc_en_out <= 1'b0;
                            state                  <= ICResp;
                        end
                    end
                    // One dead cycle so a request still held high is not looked up twice.
                    ICResp:  state <= ICIdle;
                    default: state <= ICIdle;
                endcase
            end
        end
    end

endmodule
